// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, derived totals and counter helpers
// shared by vga_sync_gen and pixel_tick_div.
package vga_timing_pkg;

  localparam int TICK_DIV = 4;

  localparam int H_DISP = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_DISP = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_DISP + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISP + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Wrapping increment: the wrap is decided by an equality compare against
  // the last legal value, never by letting the counter overflow.
  function automatic cnt_t wrapInc(input cnt_t value, input cnt_t last);
    return (value == last) ? '0 : cnt_t'(value + cnt_t'(1));
  endfunction

endpackage

// File: rtl/vga_sync_gen_div.sv
// Pixel-rate divider: a 2-bit counter cycling 0..TICK_DIV-1 on every clock,
// with a registered tick that is high exactly while the counter sits at its
// last value.
module pixel_tick_div
  import vga_timing_pkg::*;
#(
  parameter int TICK_DIV = vga_timing_pkg::TICK_DIV
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam logic [1:0] DIV_LAST = 2'(TICK_DIV - 1);

  logic [1:0] r_div;
  logic [1:0] w_divNext;
  logic       r_tick;

  // Next divider value, wrapping on an equality compare with the last count.
  always_comb begin
    w_divNext = (r_div == DIV_LAST) ? 2'd0 : 2'(r_div + 2'd1);
  end

  // Divider register; the tick is decoded from the next value so that it is
  // registered yet high in the same cycle the divider reads its last count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div  <= 2'd0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_divNext;
      r_tick <= (w_divNext == DIV_LAST);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters, registered hsync/vsync/video_on
// decoded from next-state counters, and a frame-start pulse.
// Optional macro VGA_SYNC_DELAY_EN delays hsync, vsync and video_on by two
// pixel ticks to line up with a two-register glyph lookup downstream.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int TICK_DIV = vga_timing_pkg::TICK_DIV,
  parameter int H_DISP   = vga_timing_pkg::H_DISP,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_DISP   = vga_timing_pkg::V_DISP,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic       reloj,
  input  logic       resetM,
  output logic       pixel_tick,
  output logic [9:0] Qh,
  output logic [9:0] Qv,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam cnt_t LINE_LAST  = cnt_t'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t FRAME_LAST = cnt_t'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t HS_START   = cnt_t'(H_DISP + H_FP);
  localparam cnt_t HS_END     = cnt_t'(H_DISP + H_FP + H_SYNC - 1);
  localparam cnt_t VS_START   = cnt_t'(V_DISP + V_FP);
  localparam cnt_t VS_END     = cnt_t'(V_DISP + V_FP + V_SYNC - 1);
  localparam cnt_t H_VISIBLE  = cnt_t'(H_DISP);
  localparam cnt_t V_VISIBLE  = cnt_t'(V_DISP);

  logic w_tick;
  logic w_lineWrap;
  logic w_frameWrap;
  cnt_t w_qhNext;
  cnt_t w_qvNext;
  logic w_hsyncNext;
  logic w_vsyncNext;
  logic w_videoNext;

  cnt_t r_qh;
  cnt_t r_qv;
  logic r_hsync;
  logic r_vsync;
  logic r_video;
  logic r_frameStart;

  pixel_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .i_clk  (reloj),
    .i_reset(resetM),
    .o_tick (w_tick)
  );

  // Next counter values and the sync/visible decode of those next values, so
  // the registered decode lands in the same cycle as the counters it describes.
  always_comb begin
    w_lineWrap  = w_tick && (r_qh == LINE_LAST);
    w_frameWrap = w_lineWrap && (r_qv == FRAME_LAST);
    w_qhNext    = r_qh;
    w_qvNext    = r_qv;
    if (w_tick) begin
      w_qhNext = wrapInc(r_qh, LINE_LAST);
    end
    if (w_lineWrap) begin
      w_qvNext = wrapInc(r_qv, FRAME_LAST);
    end
    w_hsyncNext = !((w_qhNext >= HS_START) && (w_qhNext <= HS_END));
    w_vsyncNext = !((w_qvNext >= VS_START) && (w_qvNext <= VS_END));
    w_videoNext = (w_qhNext < H_VISIBLE) && (w_qvNext < V_VISIBLE);
  end

  // Counter and decode registers; reset wins over any pending tick and never
  // produces a frame-start pulse of its own.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_qh         <= '0;
      r_qv         <= '0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_video      <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_qh         <= w_qhNext;
      r_qv         <= w_qvNext;
      r_hsync      <= w_hsyncNext;
      r_vsync      <= w_vsyncNext;
      r_video      <= w_videoNext;
      r_frameStart <= w_frameWrap;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [1:0] r_hsyncDly;
  logic [1:0] r_vsyncDly;
  logic [1:0] r_videoDly;

  // Two-stage pixel-rate delay of the decoded signals; counters and
  // frame_start stay undelayed.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_hsyncDly <= 2'b11;
      r_vsyncDly <= 2'b11;
      r_videoDly <= 2'b00;
    end else if (w_tick) begin
      r_hsyncDly <= {r_hsyncDly[0], r_hsync};
      r_vsyncDly <= {r_vsyncDly[0], r_vsync};
      r_videoDly <= {r_videoDly[0], r_video};
    end
  end

  assign hsync    = r_hsyncDly[1];
  assign vsync    = r_vsyncDly[1];
  assign video_on = r_videoDly[1];
`else
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign video_on = r_video;
`endif

  assign pixel_tick  = w_tick;
  assign Qh          = r_qh;
  assign Qv          = r_qv;
  assign frame_start = r_frameStart;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), with values taken from package vga_timing_pkg:
  - TICK_DIV, 4, reloj cycles per pixel.
  - H_DISP/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing.
  - V_DISP/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  - reloj, in, 1, system clock; all state updates on its rising edge.
  - resetM, in, 1, synchronous active-high reset.
  - pixel_tick, out, 1, one-reloj-cycle enable, once per TICK_DIV cycles.
  - Qh, out, 10, horizontal pixel counter 0..799.
  - Qv, out, 10, vertical line counter 0..524.
  - hsync, out, 1, horizontal sync, active-low.
  - vsync, out, 1, vertical sync, active-low.
  - video_on, out, 1, high inside the 640x480 visible area.
  - frame_start, out, 1, one-cycle pulse on frame wrap.

Function
REQ-004 A 2-bit divider SHALL count 0..3 every reloj cycle, and pixel_tick SHALL be 1 exactly when the divider equals 3.
REQ-005 Qh SHALL increment only on a reloj edge where pixel_tick=1, and SHALL wrap from 799 to 0.
REQ-006 Qv SHALL increment only on the edge where Qh wraps 799->0, and SHALL wrap from 524 to 0; Qh and Qv SHALL change on the same edge at the frame wrap.
REQ-007 All outputs SHALL be registered, and hsync, vsync and video_on SHALL be computed from next-state counter values so that they are cycle-aligned with Qh/Qv.
REQ-008 hsync SHALL be 0 when Qh is in 656..751 inclusive (96 ticks) and 1 otherwise.
REQ-009 vsync SHALL be 0 when Qv is in 490..491 inclusive (2 lines) and 1 otherwise.
REQ-010 video_on SHALL be 1 when Qh<640 and Qv<480, giving 307200 ticks per frame.
REQ-011 frame_start SHALL be 1 for exactly the one reloj cycle after the edge where (Qh,Qv) becomes (0,0).
REQ-012 Counter arithmetic SHALL be 10-bit unsigned; equality compares SHALL drive the wraps, never overflow.

Reset
REQ-013 While resetM=1 at a reloj edge, the block SHALL load: divider=0, Qh=0, Qv=0, pixel_tick=0, hsync=1, vsync=1, video_on=0, frame_start=0.
REQ-014 A reset asserted mid-frame SHALL take effect at the next edge regardless of pixel_tick, and no frame_start SHALL be generated by the reset itself.
REQ-015 The first pixel_tick after reset release SHALL occur 4 reloj cycles after the release.

Configuration
REQ-016 Macro VGA_SYNC_DELAY_EN:
  - When defined, hsync, vsync and video_on SHALL be delayed by 2 pixel ticks through a 2-stage shift register advancing on pixel_tick, to match the 2-register glyph lookup latency downstream. Qh, Qv and frame_start SHALL NOT be delayed. The delay stages SHALL reset to 1/1/0.
  - When undefined, the outputs SHALL behave exactly as REQ-008..REQ-010.

Structure
REQ-017 Package vga_timing_pkg SHALL hold all timing constants, the derived totals H_TOTAL=800 and V_TOTAL=525, and the sync start/end constants.
REQ-018 The divider SHALL be a sub-module named pixel_tick_div; the counters and sync decode SHALL live in vga_sync_gen.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - Release reset: pixel_tick first high at reloj cycle 4, then every 4 cycles; Qh goes 0->1 on that edge.
  - Line wrap: Qh=799, Qv=10 at tick -> Qh=0, Qv=11; hsync low for exactly 96 ticks, beginning at Qh=656.
  - Frame wrap: Qh=799, Qv=524 at tick -> (0,0) and frame_start high for one reloj cycle; vsync low for exactly 1600 ticks per frame.
  - video_on count over one full frame = 307200 ticks; video_on=0 at Qh=640 and at Qv=480.
  - Reset at Qh=300, Qv=200 -> next cycle Qh=0, Qv=0, hsync=1, vsync=1, video_on=0, no frame_start.
  - With VGA_SYNC_DELAY_EN: hsync falls while Qh=658, video_on falls while Qh=642; compile without the macro and check hsync falls at Qh=656.
